// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the PC, issues single-outstanding memory
// reads over req/ack, and buffers returned words in a DEPTH-entry FIFO for decode.
module fetch_queue #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               STEP     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redirect,
    input  logic [WIDTH-1:0]           redirect_pc,
    output logic                       mem_req,
    output logic [WIDTH-1:0]           mem_addr,
    input  logic                       mem_ack,
    input  logic [WIDTH-1:0]           mem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_ins,
    output logic [WIDTH-1:0]           out_pc,
    output logic [WIDTH-1:0]           out_pcp4,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int               CW     = $clog2(DEPTH + 1);
    localparam int               PW     = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    state_t           state;
    logic [WIDTH-1:0] fetch_pc;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [WIDTH-1:0] ins_q [DEPTH];
    logic [WIDTH-1:0] pc_q  [DEPTH];

    logic             push;
    logic             pop;
    logic [CW-1:0]    cnt_after;
    logic             room;
    logic [WIDTH-1:0] pc_inc;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready & ~redirect;
    assign push      = (state == S_WAIT) & mem_ack & ~redirect;
    assign pc_inc    = mem_addr + STEP_W;

    // Occupancy after this cycle's pop/push decides whether another read may launch,
    // which guarantees every acked word finds a free slot.
    always_comb begin
        cnt_after = count;
        if (push && !pop)
            cnt_after = count + CW'(1);
        else if (pop && !push)
            cnt_after = count - CW'(1);
    end

    assign room = (cnt_after < CW'(DEPTH));

    assign out_ins  = out_valid ? ins_q[rd_ptr] : '0;
    assign out_pc   = out_valid ? pc_q[rd_ptr] : '0;
    assign out_pcp4 = out_valid ? pc_q[rd_ptr] + STEP_W : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            ins_q[wr_ptr] <= mem_rdata;
            pc_q[wr_ptr]  <= mem_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (redirect) begin
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                fetch_pc <= redirect_pc;
            end else begin
                count <= cnt_after;
                if (push) begin
                    wr_ptr   <= next_ptr(wr_ptr);
                    fetch_pc <= pc_inc;
                end
                if (pop)
                    rd_ptr <= next_ptr(rd_ptr);
            end

            case (state)
                S_IDLE: begin
                    if (!redirect && room) begin
                        state    <= S_WAIT;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        if (!redirect && room) begin
                            mem_addr <= pc_inc;
                        end else begin
                            state   <= S_IDLE;
                            mem_req <= 1'b0;
                        end
                    end else if (redirect) begin
                        state <= S_DROP;
                    end
                end
                S_DROP: begin
                    // The squashed read must still complete before a new one may issue.
                    if (mem_ack) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic compared against
// a queue-based model of the fetch rules; a second instance covers PC wrap-around.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_ins;
    logic [31:0] out_pc;
    logic [31:0] out_pcp4;
    logic [2:0]  count;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic        w_ready = 1'b0;
    logic [31:0] w_ins;
    logic [31:0] w_pc;
    logic [31:0] w_pcp4;
    logic [2:0]  w_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    ent_t        m_q[$];
    bit          m_req;
    bit          m_drop;
    logic [31:0] m_addr;
    logic [31:0] m_fpc;

    always #5 clk = ~clk;

    fetch_queue #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .STEP(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins),
        .out_pc(out_pc), .out_pcp4(out_pcp4), .count(count)
    );

    assign w_ack   = w_req;
    assign w_rdata = w_addr ^ 32'h5A5A_5A5A;

    fetch_queue #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8), .STEP(4)) u_wrap (
        .clk(clk), .rst_n(rst_n), .redirect(1'b0), .redirect_pc(32'h0),
        .mem_req(w_req), .mem_addr(w_addr), .mem_ack(w_ack), .mem_rdata(w_rdata),
        .out_valid(w_valid), .out_ready(w_ready), .out_ins(w_ins),
        .out_pc(w_pc), .out_pcp4(w_pcp4), .count(w_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_req  = 1'b0;
        m_drop = 1'b0;
        m_addr = 32'h0;
        m_fpc  = 32'h0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit was_req = m_req;
        bit acked   = m_req && mem_ack;
        bit popped  = (m_q.size() != 0) && out_ready && !redirect;
        if (redirect) begin
            m_q.delete();
            m_fpc = redirect_pc;
            if (acked) begin
                m_req  = 1'b0;
                m_drop = 1'b0;
            end else if (m_req) begin
                m_drop = 1'b1;
            end
        end else begin
            if (popped)
                void'(m_q.pop_front());
            if (acked) begin
                if (!m_drop) begin
                    m_q.push_back('{mem_rdata, m_addr});
                    m_fpc = m_addr + 32'd4;
                end
                m_req = 1'b0;
                if (!m_drop && m_q.size() < DEPTH) begin
                    m_req  = 1'b1;
                    m_addr = m_fpc;
                end
                m_drop = 1'b0;
            end else if (!was_req && m_q.size() < DEPTH) begin
                m_req  = 1'b1;
                m_addr = m_fpc;
            end
        end
    endtask

    task automatic check_model();
        chk("mem_req", 32'(mem_req), 32'(m_req));
        chk("mem_addr", mem_addr, m_addr);
        chk("count", 32'(count), 32'(m_q.size()));
        chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("out_ins", out_ins, m_q[0].ins);
            chk("out_pc", out_pc, m_q[0].pc);
            chk("out_pcp4", out_pcp4, m_q[0].pc + 32'd4);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state of both instances
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_out_ins", out_ins, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_pcp4", out_pcp4, 32'h0);
        chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);

        // Release; the first request appears one cycle later
        rst_n = 1'b1;
        mem_ack = 1'b1;
        check_model();
        cycle();
        chk("first_req", 32'(mem_req), 32'h1);
        chk("first_addr", mem_addr, 32'h0);

        // Streaming fill with ack tied high and decode stalled
        for (int i = 0; i < 6; i++) begin
            mem_rdata = $urandom;
            cycle();
        end
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_req_low", 32'(mem_req), 32'h0);
        chk("fill_head_pc", out_pc, 32'h0);
        chk("fill_head_pcp4", out_pcp4, 32'h4);
        chk("wrap_count", 32'(w_count), 32'd4);
        chk("wrap_head_pc", w_pc, 32'hFFFF_FFF8);
        chk("wrap_head_pcp4", w_pcp4, 32'hFFFF_FFFC);

        // Single pop frees a slot and a read at 16 launches
        out_ready = 1'b1;
        w_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        mem_ack = 1'b0;
        chk("pop_count", 32'(count), 32'd3);
        chk("pop_next_addr", mem_addr, 32'd16);
        chk("wrap_second_pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap_second_pcp4", w_pcp4, 32'h0);
        chk("wrap_second_ins", w_ins, 32'hFFFF_FFFC ^ 32'h5A5A_5A5A);
        cycle();
        w_ready = 1'b0;
        chk("wrap_third_pc", w_pc, 32'h0);
        chk("wrap_third_pcp4", w_pcp4, 32'h4);

        // Redirect while a read is outstanding: old read is held then dropped
        redirect = 1'b1;
        redirect_pc = 32'h100;
        cycle();
        redirect = 1'b0;
        chk("redir_flush", 32'(count), 32'h0);
        chk("redir_hold_req", 32'(mem_req), 32'h1);
        chk("redir_hold_addr", mem_addr, 32'd16);
        cycle();
        cycle();
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        cycle();
        chk("drop_count", 32'(count), 32'h0);
        mem_rdata = 32'h1234_5678;
        cycle();
        chk("redir_new_addr", mem_addr, 32'h100);
        cycle();
        chk("redir_out_pc", out_pc, 32'h100);

        // Redirect coincident with ack and pop
        out_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h2000;
        cycle();
        redirect = 1'b0;
        out_ready = 1'b0;
        chk("coinc_valid", 32'(out_valid), 32'h0);
        chk("coinc_count", 32'(count), 32'h0);
        cycle();
        chk("coinc_next_addr", mem_addr, 32'h2000);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            mem_ack     = ($urandom_range(0, 9) < 6);
            mem_rdata   = $urandom;
            out_ready   = $urandom_range(0, 1) != 0;
            cycle();
        end

        // Build three entries with a read pending, then reset asynchronously
        redirect = 1'b1;
        redirect_pc = 32'h40;
        mem_ack = 1'b1;
        out_ready = 1'b0;
        cycle();
        redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rdata = $urandom;
            cycle();
        end
        mem_ack = 1'b0;
        chk("pre_rst_count", 32'(count), 32'd3);
        chk("pre_rst_req", 32'(mem_req), 32'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 32'h0);
        chk("async_req", 32'(mem_req), 32'h0);
        chk("async_count", 32'(count), 32'h0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        mem_ack = 1'b1;
        check_model();
        for (int i = 0; i < 3; i++) begin
            mem_rdata = $urandom;
            cycle();
        end
        chk("restart_head_pc", out_pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
